// File: rtl/pdp8_mem_pkg.sv
// Shared definitions for the PDP-8 core-memory cycle controller.
// Holds the transaction op encodings, the controller state enum and the
// default autoindex window (locations 0o0010..0o0017).
package pdp8_mem_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_ISZ     = 2'b10,
        OP_AUTOIDX = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPT,
        WRITE,
        DONE
    } state_e;

    localparam logic [11:0] AUTOINDEX_LO = 12'o0010;
    localparam logic [11:0] AUTOINDEX_HI = 12'o0017;

endpackage

// File: rtl/mem_cycle_ctrl.sv
// Initiator side of the PDP-8 core-memory interface.
// Accepts one transaction at a time (READ, WRITE, ISZ, AUTOIDX), owns the
// MA/MB registers and drives the RAM pins.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req, op, addr, wdata transaction request (sampled only in IDLE)
//   busy, done          controller status; done is a one-cycle pulse
//   rdata, skip         result value and ISZ-zero flag, valid with done
//   mem_oe, mem_we      RAM strobes, decoded from the state register
//   mem_addr, mem_wdata RAM address (MA) and write data (MB during WRITE)
//   mem_rdata           RAM read data (registered, oe-gated)
module mem_cycle_ctrl #(
    parameter int          AW           = 12,
    parameter int          DW           = 12,
    parameter logic [AW-1:0] AUTOINDEX_LO = pdp8_mem_pkg::AUTOINDEX_LO,
    parameter logic [AW-1:0] AUTOINDEX_HI = pdp8_mem_pkg::AUTOINDEX_HI
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          skip,
    output logic          mem_oe,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    import pdp8_mem_pkg::*;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] ma_q, ma_d;
    logic [DW-1:0] mb_q, mb_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          skip_q, skip_d;
    logic          in_window;

    assign in_window = (ma_q >= AUTOINDEX_LO) && (ma_q <= AUTOINDEX_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            ma_q    <= '0;
            mb_q    <= '0;
            rdata_q <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            rdata_q <= rdata_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        rdata_d   = rdata_q;
        skip_d    = skip_q;
        mem_oe    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    ma_d    = addr;
                    mb_d    = wdata;
                    op_d    = op_e'(op);
                    state_d = (op_e'(op) == OP_WRITE) ? WRITE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                mem_oe  = 1'b1;
                state_d = RD_CAPT;
            end
            RD_CAPT: begin
                // RAM output is oe-gated, so oe stays high while capturing.
                mem_oe = 1'b1;
                mb_d   = mem_rdata;
                if (op_q == OP_ISZ || (op_q == OP_AUTOIDX && in_window)) begin
                    mb_d    = mem_rdata + DW'(1);
                    state_d = WRITE;
                end else begin
                    // Plain read path: result and skip settle as DONE begins.
                    rdata_d = mem_rdata;
                    skip_d  = 1'b0;
                    state_d = DONE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = mb_q;
                rdata_d   = mb_q;
                skip_d    = (op_q == OP_ISZ) && (mb_q == '0);
                state_d   = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign rdata    = rdata_q;
    assign skip     = skip_q;
    assign mem_addr = ma_q;

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
module tb_mem_cycle_ctrl;

    localparam logic [1:0] T_READ  = 2'b00;
    localparam logic [1:0] T_WRITE = 2'b01;
    localparam logic [1:0] T_ISZ   = 2'b10;
    localparam logic [1:0] T_AUTO  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  op = '0;
    logic [11:0] addr = '0;
    logic [11:0] wdata = '0;
    logic        busy, done, skip, mem_oe, mem_we;
    logic [11:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [11:0] ram [0:4095];
    logic [11:0] ram_q;
    int          ref_mem [0:4095];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mem_cycle_ctrl #(.AW(12), .DW(12)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .skip(skip),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read on an oe edge, output gated by oe.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_oe) ram_q <= ram[mem_addr];
    end
    assign mem_rdata = mem_oe ? ram_q : 12'd0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    // Reference: what a transaction should do, from the op rules alone.
    task automatic model(input logic [1:0] o, input int a, input int wd,
                         output int e_rd, output int e_skip, output int e_lat,
                         output int e_we, output int e_oe);
        int v;
        bit indexed;
        indexed = (o == T_AUTO) && (a >= 8) && (a <= 15);
        e_skip = 0;
        if (o == T_WRITE) begin
            ref_mem[a] = wd;
            e_rd = wd; e_lat = 2; e_we = 1; e_oe = 0;
        end else if (o == T_ISZ || indexed) begin
            v = (ref_mem[a] + 1) % 4096;
            ref_mem[a] = v;
            e_rd = v; e_lat = 4; e_we = 1; e_oe = 'b110;
            e_skip = (o == T_ISZ && v == 0) ? 1 : 0;
        end else begin
            e_rd = ref_mem[a]; e_lat = 3; e_we = 0; e_oe = 'b110;
        end
    endtask

    task automatic run_txn(input string tag, input logic [1:0] o, input int a, input int wd);
        int e_rd, e_skip, e_lat, e_we, e_oe;
        int got_lat = 0, we_n = 0, oe_mask = 0, got_rd = -1, got_skip = -1;
        bit addr_ok = 1, busy_ok = 1;
        model(o, a, wd, e_rd, e_skip, e_lat, e_we, e_oe);
        @(negedge clk);
        chk({tag, ".idle"}, int'(busy), 0);
        req = 1'b1; op = o; addr = 12'(a); wdata = 12'(wd);
        @(posedge clk);
        #1;
        req = 1'b0; op = 2'($urandom); addr = 12'($urandom); wdata = 12'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) we_n++;
            if (mem_oe) oe_mask |= (1 << k);
            if (mem_addr !== 12'(a)) addr_ok = 0;
            if (busy !== 1'b1) busy_ok = 0;
            if (done) begin
                got_lat = k; got_rd = int'(rdata); got_skip = int'(skip);
                break;
            end
        end
        chk({tag, ".latency"}, got_lat, e_lat);
        chk({tag, ".rdata"}, got_rd, e_rd);
        chk({tag, ".skip"}, got_skip, e_skip);
        chk({tag, ".we_cycles"}, we_n, e_we);
        chk({tag, ".oe_cycles"}, oe_mask, e_oe);
        chk({tag, ".mem_addr"}, int'(addr_ok), 1);
        chk({tag, ".busy"}, int'(busy_ok), 1);
        chk({tag, ".ram"}, int'(ram[a]), ref_mem[a]);
    endtask

    initial begin
        int we_n;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = '0;
            ref_mem[i] = 0;
        end

        // 1. Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.busy", int'(busy), 0);
            chk("rst.done", int'(done), 0);
            chk("rst.oe", int'(mem_oe), 0);
            chk("rst.we", int'(mem_we), 0);
            chk("rst.rdata", int'(rdata), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst.busy", int'(busy), 0);
        chk("post_rst.addr", int'(mem_addr), 0);

        // 2. WRITE then READ
        run_txn("wr200", T_WRITE, 'o200, 'o1234);
        run_txn("rd200", T_READ, 'o200, 0);

        // 3. ISZ wrap and non-zero
        run_txn("wr300", T_WRITE, 'o300, 'o7777);
        run_txn("isz_wrap", T_ISZ, 'o300, 0);
        run_txn("isz_one", T_ISZ, 'o300, 0);

        // 4. Autoindex boundaries
        run_txn("pre7", T_WRITE, 'o7, 'o100);
        run_txn("pre10", T_WRITE, 'o10, 'o100);
        run_txn("pre17", T_WRITE, 'o17, 'o100);
        run_txn("pre20", T_WRITE, 'o20, 'o100);
        run_txn("ai10", T_AUTO, 'o10, 0);
        run_txn("ai17", T_AUTO, 'o17, 0);
        run_txn("ai7", T_AUTO, 'o7, 0);
        run_txn("ai20", T_AUTO, 'o20, 0);

        // skip must clear on a following non-ISZ transaction
        run_txn("wr301", T_WRITE, 'o301, 'o7777);
        run_txn("isz301", T_ISZ, 'o301, 0);
        run_txn("rd_after_skip", T_READ, 'o301, 0);

        // 1b. Reset asserted during RD_CAPT
        @(negedge clk);
        req = 1'b1; op = T_READ; addr = 12'o200;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.oe_before", int'(mem_oe), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.oe", int'(mem_oe), 0);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.rdata", int'(rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.idle", int'(busy), 0);
        run_txn("rd_after_rst", T_READ, 'o200, 0);

        // 5. Request held high, inputs changed while busy
        @(negedge clk);
        req = 1'b1; op = T_WRITE; addr = 12'o400; wdata = 12'o55;
        @(posedge clk);
        #1 addr = 12'o500; wdata = 12'o66;
        we_n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_n++;
                chk($sformatf("hold.we_addr%0d", k), int'(mem_addr), (k == 1) ? 'o400 : 'o500);
            end
            if (k == 1 || k == 4) chk($sformatf("hold.we%0d", k), int'(mem_we), 1);
            if (k == 2 || k == 5) chk($sformatf("hold.done%0d", k), int'(done), 1);
            if (k == 3) chk("hold.idle_gap", int'(busy), 0);
            if (k == 4) req = 1'b0;
        end
        chk("hold.we_total", we_n, 2);
        ref_mem['o400] = 'o55;
        ref_mem['o500] = 'o66;
        chk("hold.ram400", int'(ram['o400]), 'o55);
        chk("hold.ram500", int'(ram['o500]), 'o66);

        // Randomized mix, addresses biased around the autoindex window
        for (int n = 0; n < 150; n++) begin
            int a;
            a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(5, 18)) : int'($urandom_range(0, 4095));
            run_txn($sformatf("rnd%0d", n), 2'($urandom), a, int'($urandom_range(0, 4095)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_cycle_ctrl.md
Name: mem_cycle_ctrl

Overview:
- Initiator side of the 12-bit PDP-8 core-memory interface.
- Accepts one memory transaction at a time from the CPU sequencer: read, write, increment-and-write-back (ISZ), or autoindex read.
- Drives the RAM's oe/we/addr/dataI pins and captures dataO.
- Owns the MA/MB registers. Sits between the CPU control FSM and the RAM block.

Parameters:
- AW, 12, address width.
- DW, 12, data width.
- AUTOINDEX_LO, 12'o0010, first autoindex location.
- AUTOINDEX_HI, 12'o0017, last autoindex location.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  1  transaction request, sampled only in IDLE
- op  input  2  00 READ, 01 WRITE, 10 ISZ, 11 AUTOIDX
- addr  input  AW  transaction address
- wdata  input  DW  write data (WRITE only)
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- rdata  output  DW  read or updated value, valid while done=1 and held until next done
- skip  output  1  ISZ result was zero, valid with done
- mem_oe  output  1  to RAM oe
- mem_we  output  1  to RAM we
- mem_addr  output  AW  to RAM addr (MA register)
- mem_wdata  output  DW  to RAM dataI
- mem_rdata  input  DW  from RAM dataO

Behaviour:

Clock and reset:
- One clock: clk. Reset rst_n is asynchronous, active-low.
- Reset clears state to IDLE, and clears MA, MB, rdata and skip to 0.
- All outputs read 0 during and immediately after reset.
- mem_oe and mem_we are decoded from the state register, so reset forces them low asynchronously, including mid-transaction. An interrupted write is simply not performed.

RAM timing contract:
- The RAM registers the read on the clk edge where oe=1.
- Its output is gated by oe, so mem_oe must stay high in the cycle after issue, when data is captured.

States and transitions:
- IDLE
  - If req=1: latch addr→MA, wdata→MB, op→OP.
  - Go to WRITE if op=WRITE, otherwise to RD_ISSUE.
- RD_ISSUE
  - mem_oe=1.
  - Go to RD_CAPT.
- RD_CAPT
  - mem_oe=1; MB ← mem_rdata.
  - READ, or AUTOIDX with MA outside [LO,HI]: go to DONE, rdata ← mem_rdata.
  - ISZ, or AUTOIDX with MA in range: MB ← mem_rdata+1 (12-bit wrap, 7777+1=0000), then go to WRITE.
- WRITE
  - mem_we=1, mem_wdata=MB.
  - rdata ← MB.
  - skip ← (OP==ISZ && MB==0).
  - Go to DONE.
- DONE
  - done=1.
  - Go to IDLE.

Output rules:
- mem_wdata is 0 outside WRITE.
- mem_addr always equals MA.
- skip is cleared on the DONE of any non-ISZ transaction.

Latency (accept edge = cycle 0):
- done at cycle 2 for WRITE.
- done at cycle 3 for READ and non-indexed AUTOIDX.
- done at cycle 4 for ISZ and indexed AUTOIDX.

Request handling:
- req is ignored in every state except IDLE.
- A req held high continuously gets its next transaction accepted on the IDLE cycle following DONE.
- Inputs changing after accept have no effect.

Boundary rules:
- Addresses 0o0007 and 0o0020 are not autoindexed.
- Addresses 0o0010 and 0o0017 are autoindexed.
- AUTOIDX never sets skip.

Decomposition:
- Package pdp8_mem_pkg holds:
  - op encodings (OP_READ, OP_WRITE, OP_ISZ, OP_AUTOIDX);
  - state enum (IDLE, RD_ISSUE, RD_CAPT, WRITE, DONE);
  - AUTOINDEX_LO/HI constants.
- No sub-module needed.
- The incrementer and range compare are inline expressions.

Test Plan:

The bench connects the block to a behavioural RAM model with one-cycle registered read and oe-gated output.

1. Reset and mid-operation reset
   - Reset, then hold rst_n=0 for 3 cycles → busy, done, mem_oe, mem_we and rdata all 0.
   - Assert rst_n=0 during RD_CAPT → mem_oe drops immediately and the block resumes in IDLE.
2. WRITE then READ
   - WRITE addr=0o0200, wdata=0o1234 → mem_we high exactly 1 cycle, done at cycle 2.
   - READ 0o0200 → rdata=0o1234 at cycle 3; mem_oe high in cycles 1–2 only.
3. ISZ wrap and non-zero
   - mem[0o0300]=0o7777, ISZ 0o0300 → done at cycle 4, rdata=0o0000, skip=1, mem[0o0300]=0.
   - Repeat ISZ → rdata=0o0001, skip=0.
4. AUTOIDX boundaries
   - Preload mem[0o0007]=0o0100, mem[0o0010]=0o0100, mem[0o0017]=0o0100, mem[0o0020]=0o0100.
   - 0o0010 and 0o0017 → rdata=0o0101, memory updated, done at cycle 4.
   - 0o0007 and 0o0020 → rdata=0o0100, no mem_we, done at cycle 3, skip=0.
5. Request hold and input stability
   - req held high with WRITE 0o0400 ← 0o0055; change addr/wdata during busy → exactly one write to 0o0400.
   - The second transaction is accepted on the IDLE cycle after DONE, with no gap-free overlap.
